sram_like_arbiter: RTL

- Parametrised N-channel to 1-port arbiter for the SRAM-like request/response protocol (req/addr_ok/data_ok).
- Next generation of the core's memory front end: merges the instruction-fetch, data and future master channels onto one downstream port that feeds the AXI bridge.
- Round-robin address-phase arbitration; in-order response routing through an outstanding-transaction ID FIFO.

---
 rtl/sram_like_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: round-robin N-to-1 SRAM-like arbiter with in-order response routing via an ID FIFO
module sram_like_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            m_req,
  input  logic [NUM_CH-1:0]            m_wr,
  input  logic [2*NUM_CH-1:0]          m_size,
  input  logic [NUM_CH*DATA_W/8-1:0]   m_wstrb,
  input  logic [NUM_CH*ADDR_W-1:0]     m_addr,
  input  logic [NUM_CH*DATA_W-1:0]     m_wdata,
  output logic [NUM_CH-1:0]            m_addr_ok,
  output logic [NUM_CH-1:0]            m_data_ok,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         s_req,
  output logic                         s_wr,
  output logic [1:0]                   s_size,
  output logic [DATA_W/8-1:0]          s_wstrb,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic                         s_addr_ok,
  input  logic                         s_data_ok,
  input  logic [DATA_W-1:0]            s_rdata,
  output logic                         err
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int SW = DATA_W / 8;
  logic [CH_W-1:0] prio_ptr, lock_ch, rr_ch, sel, sel_next;
  logic locked, rr_found, sel_req;
  logic [CH_W-1:0] fifo_mem [MAX_OUT];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic fifo_full, fifo_empty, push, pop;
  int idx;
  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    rr_ch = prio_ptr;
    rr_found = 1'b0;
    idx = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(prio_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (m_req[CH_W'(idx)]) begin
        rr_ch = CH_W'(idx);
        rr_found = 1'b1;
      end
    end
  end
  assign sel = locked ? lock_ch : rr_ch;
  assign sel_req = locked ? m_req[sel] : rr_found;
  assign sel_next = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
  assign fifo_full = count == CNT_W'(MAX_OUT);
  assign fifo_empty = count == '0;
  assign s_req = sel_req & ~fifo_full;
  assign push = s_req & s_addr_ok;
  assign pop = s_data_ok & ~fifo_empty;
  assign s_wr = s_req & m_wr[sel];
  assign s_size = s_req ? m_size[int'(sel)*2 +: 2] : '0;
  assign s_wstrb = s_req ? m_wstrb[int'(sel)*SW +: SW] : '0;
  assign s_addr = s_req ? m_addr[int'(sel)*ADDR_W +: ADDR_W] : '0;
  assign s_wdata = s_req ? m_wdata[int'(sel)*DATA_W +: DATA_W] : '0;
  assign m_rdata = s_rdata;
  always_comb begin
    m_addr_ok = '0;
    m_addr_ok[sel] = push;
    m_data_ok = '0;
    m_data_ok[fifo_mem[rptr]] = pop;
  end
  always_ff @(posedge clk) if (push) fifo_mem[wptr] <= sel;
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_ptr <= '0;
      locked <= 1'b0;
      lock_ch <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      if (push) begin
        prio_ptr <= sel_next;
        locked <= 1'b0;
      end else if (s_req) begin
        locked <= 1'b1;
        lock_ch <= sel;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (s_data_ok & fifo_empty) err <= 1'b1;
    end
  end
endmodule
